// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, mux/ALU encodings, sequencer states
// and the per-state Moore control decode.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'b000000;
    localparam logic [5:0] LW     = 6'b100011;
    localparam logic [5:0] SW     = 6'b101011;
    localparam logic [5:0] BEQ    = 6'b000100;
    localparam logic [5:0] BNE    = 6'b000101;
    localparam logic [5:0] ADDI   = 6'b001000;
    localparam logic [5:0] J      = 6'b000010;
    localparam logic [5:0] JAL    = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic       SRC_A_PC   = 1'b0;
    localparam logic       SRC_A_REG  = 1'b1;
    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;
    localparam logic [1:0] SRC_B_BOFF = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REGA   = 2'b11;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] TOREG_ALUOUT = 2'b00;
    localparam logic [1:0] TOREG_MDR    = 2'b01;
    localparam logic [1:0] TOREG_PC     = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14,
        S_ERROR     = 4'd15
    } state_t;

    // Moore part of the controls; the *_gate/branch/jr fields are qualified
    // later by live mem_ready, zero or the captured JR flag.
    typedef struct packed {
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] reg_dst;
        logic [1:0] mem_toreg;
        logic       reg_write;
        logic       pc_write;
        logic       fetch_gate;
        logic       branch;
        logic       jr_jump;
        logic       done;
        logic       done_on_ready;
        logic       err;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_a  = SRC_A_PC;
                c.alu_src_b  = SRC_B_FOUR;
                c.alu_op     = ALU_ADD;
                c.pc_source  = PC_SRC_ALU;
                c.fetch_gate = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRC_A_PC;
                c.alu_src_b = SRC_B_BOFF;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                c.alu_src_a = SRC_A_REG;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_dst   = REG_DST_RT;
                c.mem_toreg = TOREG_MDR;
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write     = 1'b1;
                c.iord          = 1'b1;
                c.done_on_ready = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = SRC_A_REG;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_dst   = REG_DST_RD;
                c.mem_toreg = TOREG_ALUOUT;
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_ADDI_WB: begin
                c.reg_dst   = REG_DST_RT;
                c.mem_toreg = TOREG_ALUOUT;
                c.reg_write = 1'b1;
                c.done      = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = SRC_A_REG;
                c.alu_src_b = SRC_B_REG;
                c.alu_op    = ALU_SUB;
                c.pc_source = PC_SRC_ALUOUT;
                c.branch    = 1'b1;
                c.done      = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
                c.done      = 1'b1;
            end
            S_JAL: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
                c.reg_write = 1'b1;
                c.reg_dst   = REG_DST_RA;
                c.mem_toreg = TOREG_PC;
                c.done      = 1'b1;
            end
            S_JR: begin
                c.pc_source = PC_SRC_REGA;
                c.jr_jump   = 1'b1;
                c.done      = 1'b1;
            end
            S_ERROR: begin
                c.err = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_32.sv
// Multi-cycle MIPS sequencer: one FSM sharing the ALU and memory port across
// cycles, with registered Moore controls and live mem_ready/zero qualification.
module multicycle_control_32
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_toreg,
    output logic             reg_write,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             err_illegal_opcode
);

    state_t           state_r;
    state_t           next_state_s;
    ctrl_t            ctrl_r;
    ctrl_t            ctrl_next_s;
    logic [5:0]       op_q;
    logic             is_jr_q;
    logic [CNT_W-1:0] count_r;
    logic             is_bne_s;
    logic             instr_done_s;

    // Next-state selection; only DECODE looks at the live IR.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:   next_state_s = S_FETCH;
            S_FETCH:  next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    R_TYPE: begin
                        if (funct == F_JR) begin
                            next_state_s = S_JR;
                        end else begin
                            next_state_s = S_R_EXEC;
                        end
                    end
                    LW, SW:   next_state_s = S_MEM_ADDR;
                    BEQ, BNE: next_state_s = S_BRANCH;
                    ADDI:     next_state_s = S_ADDI_EXEC;
                    J:        next_state_s = S_JUMP;
                    JAL:      next_state_s = S_JAL;
                    default:  next_state_s = S_ERROR;
                endcase
            end
            S_MEM_ADDR:  next_state_s = (op_q == LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    next_state_s = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:    next_state_s = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    next_state_s = S_R_WB;
            S_ADDI_EXEC: next_state_s = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB,
            S_BRANCH, S_JUMP, S_JAL, S_JR: next_state_s = S_FETCH;
            S_ERROR:     next_state_s = S_ERROR;
            default:     next_state_s = S_ERROR;
        endcase
    end

    // Output decode of the upcoming state so the controls leave a register.
    always_comb begin
        ctrl_next_s = decode_ctrl(next_state_s);
    end

    assign is_bne_s     = (op_q == BNE);
    assign instr_done_s = ctrl_r.done | (ctrl_r.done_on_ready & mem_ready);

    // State, captured instruction fields, registered controls and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            ctrl_r  <= '0;
            op_q    <= 6'b000000;
            is_jr_q <= 1'b0;
            count_r <= '0;
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= ctrl_next_s;
            if (state_r == S_DECODE) begin
                op_q    <= opcode;
                is_jr_q <= (opcode == R_TYPE) && (funct == F_JR);
            end
            if (instr_done_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign iord               = ctrl_r.iord;
    assign mem_read           = ctrl_r.mem_read;
    assign mem_write          = ctrl_r.mem_write;
    assign alu_src_a          = ctrl_r.alu_src_a;
    assign alu_src_b          = ctrl_r.alu_src_b;
    assign alu_op             = ctrl_r.alu_op;
    assign pc_source          = ctrl_r.pc_source;
    assign reg_dst            = ctrl_r.reg_dst;
    assign mem_toreg          = ctrl_r.mem_toreg;
    assign reg_write          = ctrl_r.reg_write;
    assign err_illegal_opcode = ctrl_r.err;
    assign ir_write           = ctrl_r.fetch_gate & mem_ready;
    assign pc_write           = ctrl_r.pc_write
                              | (ctrl_r.fetch_gate & mem_ready)
                              | (ctrl_r.branch & (zero ^ is_bne_s))
                              | (ctrl_r.jr_jump & is_jr_q);
    assign instr_done         = instr_done_s;
    assign instr_count        = count_r;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Self-checking bench for multicycle_control_32: directed vector table, hand
// sequences for waits/error/reset, and random programs against a step model.
module tb_multicycle_control_32;

    localparam int CNT_W = 32;

    typedef struct packed {
        logic       pc_write, iord, mem_read, mem_write, ir_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source, reg_dst, mem_toreg;
        logic       reg_write, instr_done, err;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        out_t       exp;
        int         cnt;
    } vec_t;

    localparam out_t O_IDLE       = '0;
    localparam out_t O_FETCH      = '{pc_write: 1'b1, mem_read: 1'b1, ir_write: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam out_t O_FETCH_WAIT = '{mem_read: 1'b1, alu_src_b: 2'b01, default: '0};
    localparam out_t O_DECODE     = '{alu_src_b: 2'b11, default: '0};
    localparam out_t O_IMM_EXEC   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0};
    localparam out_t O_R_EXEC     = '{alu_src_a: 1'b1, alu_op: 2'b10, default: '0};
    localparam out_t O_R_WB       = '{reg_dst: 2'b01, reg_write: 1'b1, instr_done: 1'b1, default: '0};
    localparam out_t O_ADDI_WB    = '{reg_write: 1'b1, instr_done: 1'b1, default: '0};
    localparam out_t O_BR_TAKEN   = '{pc_write: 1'b1, alu_src_a: 1'b1, alu_op: 2'b01, pc_source: 2'b01, instr_done: 1'b1, default: '0};
    localparam out_t O_BR_NOT     = '{alu_src_a: 1'b1, alu_op: 2'b01, pc_source: 2'b01, instr_done: 1'b1, default: '0};
    localparam out_t O_JUMP       = '{pc_write: 1'b1, pc_source: 2'b10, instr_done: 1'b1, default: '0};
    localparam out_t O_JAL        = '{pc_write: 1'b1, pc_source: 2'b10, reg_write: 1'b1, reg_dst: 2'b10, mem_toreg: 2'b10, instr_done: 1'b1, default: '0};
    localparam out_t O_JR         = '{pc_write: 1'b1, pc_source: 2'b11, instr_done: 1'b1, default: '0};
    localparam out_t O_MEM_RD     = '{mem_read: 1'b1, iord: 1'b1, default: '0};
    localparam out_t O_MEM_WB     = '{mem_toreg: 2'b01, reg_write: 1'b1, instr_done: 1'b1, default: '0};
    localparam out_t O_MEM_WR     = '{mem_write: 1'b1, iord: 1'b1, default: '0};
    localparam out_t O_MEM_WR_END = '{mem_write: 1'b1, iord: 1'b1, instr_done: 1'b1, default: '0};
    localparam out_t O_ERR        = '{err: 1'b1, default: '0};

    logic             clk;
    logic             rst_n;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write, iord, mem_read, mem_write, ir_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source, reg_dst, mem_toreg;
    logic             reg_write, instr_done, err_illegal_opcode;
    logic [CNT_W-1:0] instr_count;
    out_t             got;

    int n_checks = 0;
    int n_fail   = 0;
    int ir_seen, cyc_no, last_done_at;
    int exp_count;
    vec_t tbl[$];

    multicycle_control_32 #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .reg_dst(reg_dst), .mem_toreg(mem_toreg), .reg_write(reg_write),
        .instr_done(instr_done), .instr_count(instr_count),
        .err_illegal_opcode(err_illegal_opcode)
    );

    assign got = {pc_write, iord, mem_read, mem_write, ir_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, reg_dst, mem_toreg,
                  reg_write, instr_done, err_illegal_opcode};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input out_t exp, input int cnt);
        n_checks++;
        if (got.ir_write) ir_seen++;
        if (got.instr_done) last_done_at = cyc_no;
        cyc_no++;
        if (got !== exp || instr_count !== CNT_W'(cnt)) begin
            n_fail++;
            $display("FAIL %s: got out=%05h count=%0d, expected out=%05h count=%0d",
                     name, got, instr_count, exp, cnt);
        end
    endtask

    // Called at posedge+1: apply inputs, check at the falling edge, move to next posedge+1.
    task automatic cyc(input string name, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input out_t exp, input int cnt);
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        @(negedge clk);
        check(name, exp, cnt);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic add(input string n, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input out_t e, input int c);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e; v.cnt = c;
        tbl.push_back(v);
    endtask

    function automatic out_t exp_out(input string s, input logic rdy, input logic z, input logic bne);
        out_t e = '0;
        case (s)
            "fetch":  begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            "decode": e.alu_src_b = 2'b11;
            "addr", "aexec": begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
            "memrd":  begin e.mem_read = 1'b1; e.iord = 1'b1; end
            "memwb":  begin e.mem_toreg = 2'b01; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            "memwr":  begin e.mem_write = 1'b1; e.iord = 1'b1; e.instr_done = rdy; end
            "rexec":  begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
            "rwb":    begin e.reg_dst = 2'b01; e.reg_write = 1'b1; e.instr_done = 1'b1; end
            "awb":    begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            "branch": begin
                e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_source = 2'b01;
                e.pc_write = z ^ bne; e.instr_done = 1'b1;
            end
            "jump":   begin e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1; end
            "jal":    begin
                e.pc_write = 1'b1; e.pc_source = 2'b10; e.reg_write = 1'b1;
                e.reg_dst = 2'b10; e.mem_toreg = 2'b10; e.instr_done = 1'b1;
            end
            "jr":     begin e.pc_write = 1'b1; e.pc_source = 2'b11; e.instr_done = 1'b1; end
            default:  e.err = 1'b1;
        endcase
        return e;
    endfunction

    // One instruction as a list of named steps; waiting steps repeat while mem_ready is low.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
        string s;
        string steps[$];
        int    i = 0;
        int    waits = 0;
        logic  z, rdy;
        out_t  e;
        steps = {"fetch", "decode"};
        case (op)
            6'b000000: if (fn == 6'b001000) steps.push_back("jr");
                       else begin steps.push_back("rexec"); steps.push_back("rwb"); end
            6'b100011: begin steps.push_back("addr"); steps.push_back("memrd"); steps.push_back("memwb"); end
            6'b101011: begin steps.push_back("addr"); steps.push_back("memwr"); end
            6'b000100, 6'b000101: steps.push_back("branch");
            6'b001000: begin steps.push_back("aexec"); steps.push_back("awb"); end
            6'b000010: steps.push_back("jump");
            6'b000011: steps.push_back("jal");
            default:   steps.push_back("error");
        endcase
        while (i < steps.size()) begin
            s   = steps[i];
            z   = 1'($urandom);
            rdy = ($urandom_range(3) != 0) || (waits > 20);
            e   = exp_out(s, rdy, z, op == 6'b000101);
            if (s == "decode") cyc(s, op, fn, z, rdy, e, exp_count);
            else               cyc(s, 6'($urandom), 6'($urandom), z, rdy, e, exp_count);
            if (e.instr_done) exp_count++;
            if ((s == "fetch" || s == "memrd" || s == "memwr") && !rdy) waits++;
            else begin i++; waits = 0; end
        end
    endtask

    initial begin
        logic [5:0] legal [8];
        logic [5:0] op, fn;
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b000011};

        add("idle",      6'h00, 6'h20, 1'b0, 1'b1, O_IDLE,     0);
        add("add_fetch", 6'h00, 6'h20, 1'b0, 1'b1, O_FETCH,    0);
        add("add_dec",   6'h00, 6'h20, 1'b0, 1'b1, O_DECODE,   0);
        add("add_exec",  6'h00, 6'h20, 1'b0, 1'b1, O_R_EXEC,   0);
        add("add_wb",    6'h00, 6'h20, 1'b0, 1'b1, O_R_WB,     0);
        add("beq1_f",    6'h04, 6'h00, 1'b1, 1'b1, O_FETCH,    1);
        add("beq1_d",    6'h04, 6'h00, 1'b1, 1'b1, O_DECODE,   1);
        add("beq1_br",   6'h04, 6'h00, 1'b1, 1'b1, O_BR_TAKEN, 1);
        add("bne1_f",    6'h05, 6'h00, 1'b1, 1'b1, O_FETCH,    2);
        add("bne1_d",    6'h05, 6'h00, 1'b1, 1'b1, O_DECODE,   2);
        add("bne1_br",   6'h05, 6'h00, 1'b1, 1'b1, O_BR_NOT,   2);
        add("jal_f",     6'h03, 6'h00, 1'b0, 1'b1, O_FETCH,    3);
        add("jal_d",     6'h03, 6'h00, 1'b0, 1'b1, O_DECODE,   3);
        add("jal_x",     6'h03, 6'h00, 1'b0, 1'b1, O_JAL,      3);
        add("jr_f",      6'h00, 6'h08, 1'b0, 1'b1, O_FETCH,    4);
        add("jr_d",      6'h00, 6'h08, 1'b0, 1'b1, O_DECODE,   4);
        add("jr_x",      6'h00, 6'h08, 1'b0, 1'b1, O_JR,       4);
        add("j_f",       6'h02, 6'h00, 1'b0, 1'b1, O_FETCH,    5);
        add("j_d",       6'h02, 6'h00, 1'b0, 1'b1, O_DECODE,   5);
        add("j_x",       6'h02, 6'h00, 1'b0, 1'b1, O_JUMP,     5);
        add("addi_f",    6'h08, 6'h00, 1'b0, 1'b1, O_FETCH,    6);
        add("addi_d",    6'h08, 6'h00, 1'b0, 1'b1, O_DECODE,   6);
        add("addi_x",    6'h08, 6'h00, 1'b0, 1'b1, O_IMM_EXEC, 6);
        add("addi_wb",   6'h08, 6'h00, 1'b0, 1'b1, O_ADDI_WB,  6);
        add("sw_f",      6'h2b, 6'h00, 1'b0, 1'b1, O_FETCH,    7);
        add("sw_d",      6'h2b, 6'h00, 1'b0, 1'b1, O_DECODE,   7);
        add("sw_addr",   6'h2b, 6'h00, 1'b0, 1'b1, O_IMM_EXEC, 7);
        add("sw_wr",     6'h2b, 6'h00, 1'b0, 1'b1, O_MEM_WR_END, 7);
        add("beq0_f",    6'h04, 6'h00, 1'b0, 1'b1, O_FETCH,    8);
        add("beq0_d",    6'h04, 6'h00, 1'b0, 1'b1, O_DECODE,   8);
        add("beq0_br",   6'h04, 6'h00, 1'b0, 1'b1, O_BR_NOT,   8);
        add("bne0_f",    6'h05, 6'h00, 1'b0, 1'b1, O_FETCH,    9);
        add("bne0_d",    6'h05, 6'h00, 1'b0, 1'b1, O_DECODE,   9);
        add("bne0_br",   6'h05, 6'h00, 1'b0, 1'b1, O_BR_TAKEN, 9);
        add("fetch_wait", 6'h2b, 6'h00, 1'b0, 1'b0, O_FETCH_WAIT, 10);

        do_reset();
        foreach (tbl[i]) cyc(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy, tbl[i].exp, tbl[i].cnt);

        // SW stalled in MEM_WR, then reset with no clock edge in between.
        cyc("sw2_f",    6'h2b, 6'h00, 1'b0, 1'b1, O_FETCH,    10);
        cyc("sw2_d",    6'h2b, 6'h00, 1'b0, 1'b0, O_DECODE,   10);
        cyc("sw2_addr", 6'h2b, 6'h00, 1'b0, 1'b0, O_IMM_EXEC, 10);
        cyc("sw2_wait", 6'h2b, 6'h00, 1'b0, 1'b0, O_MEM_WR,   10);
        #2 rst_n = 1'b0;
        #1 check("rst_in_memwr", O_IDLE, 0);

        // LW with two fetch waits and three read waits.
        do_reset();
        cyc("lw_idle", 6'h23, 6'h00, 1'b0, 1'b0, O_IDLE, 0);
        ir_seen = 0; cyc_no = 0; last_done_at = -1;
        cyc("lw_fwait1", 6'h23, 6'h00, 1'b0, 1'b0, O_FETCH_WAIT, 0);
        cyc("lw_fwait2", 6'h23, 6'h00, 1'b0, 1'b0, O_FETCH_WAIT, 0);
        cyc("lw_fetch",  6'h23, 6'h00, 1'b0, 1'b1, O_FETCH,      0);
        cyc("lw_dec",    6'h23, 6'h00, 1'b0, 1'b0, O_DECODE,     0);
        cyc("lw_addr",   6'h00, 6'h08, 1'b0, 1'b0, O_IMM_EXEC,   0);
        for (int k = 0; k < 3; k++) cyc("lw_rwait", 6'h2b, 6'h00, 1'b1, 1'b0, O_MEM_RD, 0);
        cyc("lw_rd",     6'h2b, 6'h00, 1'b0, 1'b1, O_MEM_RD,     0);
        cyc("lw_wb",     6'h2b, 6'h00, 1'b0, 1'b0, O_MEM_WB,     0);
        n_checks++;
        if (ir_seen != 1) begin
            n_fail++;
            $display("FAIL lw_ir_pulses: got %0d, expected 1", ir_seen);
        end
        n_checks++;
        if (last_done_at + 1 != 10) begin
            n_fail++;
            $display("FAIL lw_cycles: got %0d, expected 10", last_done_at + 1);
        end
        cyc("lw_next", 6'h00, 6'h00, 1'b0, 1'b0, O_FETCH_WAIT, 1);

        // Illegal opcode: absorbing error until reset.
        do_reset();
        cyc("err_idle",  6'h3f, 6'h00, 1'b0, 1'b1, O_IDLE,   0);
        cyc("err_fetch", 6'h3f, 6'h00, 1'b0, 1'b1, O_FETCH,  0);
        cyc("err_dec",   6'h3f, 6'h00, 1'b0, 1'b1, O_DECODE, 0);
        for (int k = 0; k < 20; k++) cyc("err_hold", 6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), O_ERR, 0);
        #2 rst_n = 1'b0;
        #1 check("err_async_rst", O_IDLE, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc("err_reidle", 6'h00, 6'h00, 1'b1, 1'b1, O_IDLE, 0);

        // Random legal programs with random waits, zero and IR noise.
        exp_count = 0;
        for (int n = 0; n < 300; n++) begin
            op = legal[$urandom_range(7)];
            fn = 6'($urandom);
            if (op == 6'b000000 && $urandom_range(3) == 0) fn = 6'b001000;
            run_instr(op, fn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
